chaser_controller: RTL
======================

Name: chaser_controller

Overview:
Command-driven sequencer for the team's LED chaser datapath. Owns the step prescaler, run/pause/idle state and pattern mode, and produces the WIDTH-bit light vector.
Replaces the fixed shift-every-5-clocks behaviour with a programmable scheduler. Commands arrive over a valid/ready interface from a host or button-decoder block.

Parameters:
WIDTH, 8, number of LEDs (>=2)
DIV_W, 16, width of step-period divider register
DEFAULT_DIV, 4, reset divider value; a step occurs every DIV+1 cycles, so the default is one step per 5 clocks

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high
enable  input  1  global enable; low freezes all state
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command
cmd_op  input  3  opcode (see Behaviour)
cmd_arg  input  DIV_W  command argument
light  output  WIDTH  LED pattern
state  output  2  0=IDLE, 1=RUN, 2=PAUSE
step_pulse  output  1  one-cycle pulse on every pattern advance

Behaviour:
- Reset (rst=1 at clk edge, regardless of enable) sets:
  - state=IDLE, light=0, mode=0, div=DEFAULT_DIV, dir=left, prescaler=0, step_pulse=0.
- enable=0: no register changes except reset; cmd_ready=0; step_pulse=0.
- cmd_ready = enable (combinational). A command is accepted when cmd_valid and cmd_ready are both high at a clock edge; its effect is visible the next cycle.
- Opcodes:
  - 0 NOP: no effect.
  - 1 START: state=RUN, light=seed(mode), prescaler=0, dir=left.
  - 2 STOP: state=IDLE, light=0, prescaler=0.
  - 3 PAUSE: RUN->PAUSE, PAUSE->RUN; ignored in IDLE. Prescaler is held, not cleared.
  - 4 SET_MODE: mode=cmd_arg[1:0], prescaler=0, dir=left. Reloads light=seed(mode) if not IDLE.
  - 5 SET_DIV: div=cmd_arg, prescaler=0.
  - 6 STEP: in PAUSE only, advance pattern once and pulse step_pulse; ignored otherwise.
  - 7: reserved, treated as NOP.
- Seeds: modes 0, 2 and 3 use 1 (LSB). Mode 1 uses 1<<(WIDTH-1) (MSB).
- Prescaler, RUN only: if prescaler==div then advance pattern, step_pulse=1 and prescaler=0; else prescaler+1.
  - div=0 steps every cycle.
  - A SET_DIV to a value below the current prescaler is safe because the prescaler is cleared.
- Pattern advance per mode:
  - 0 chase-left: shift left; MSB wraps to LSB.
  - 1 chase-right: shift right; LSB wraps to MSB.
  - 2 bounce: shift in dir; on reaching MSB set dir=right, on reaching LSB set dir=left. With WIDTH=8 the sequence is 01,02..80,40..01,02 (no repeated endpoint).
  - 3 fill: light=(light<<1)|1; all-ones next goes to 0x..01.
- Simultaneous command and prescaler step in the same cycle: the command wins and the step is suppressed (no step_pulse).
- light is never 0 while state is RUN or PAUSE.

Optional Feature:
CHASER_LAP_CNT_EN
- Defined: adds ports lap_done (output, 1) and lap_count (output, 8).
  - lap_done pulses in the same cycle as the step_pulse whose advance returns light to seed(mode). In bounce mode this is a full there-and-back lap.
  - lap_count increments on each lap_done and wraps at 255.
  - Both are cleared by reset, STOP, START and SET_MODE.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Reset then START with default div, mode 0 -> light=01 next cycle; step_pulse every 5 cycles; light 02,04..80,01 (wraps after 8 steps).
2. SET_DIV arg=0, SET_MODE 2, START -> light steps every cycle: 01,02,..,80,40,..,01,02; state=1 throughout.
3. RUN in mode 3, PAUSE after light=07, hold 20 cycles -> light stays 07, no step_pulse. STEP -> 0F with one step_pulse. PAUSE again -> resumes RUN with remaining prescaler count.
4. Issue SET_DIV=9 in the exact cycle the prescaler hits div -> no advance that cycle; the next step occurs 10 cycles later.
5. Drop enable mid-RUN for 7 cycles -> light, prescaler and state frozen, cmd_ready=0, a valid command is not accepted. Assert rst with enable=0 -> light=0, state=0.
6. With CHASER_LAP_CNT_EN, mode 0, div=0 for 24 steps -> lap_done pulses 3 times, lap_count=3. STOP -> lap_count=0.

Source files
------------

// File: rtl/chaser_controller.sv
// Command-driven LED chaser sequencer: prescaler, run/pause/idle, pattern modes.
// Optional CHASER_LAP_CNT_EN adds lap_done / lap_count outputs.
module chaser_controller #(
  parameter int WIDTH       = 8,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [DIV_W-1:0] cmd_arg,
  output logic [WIDTH-1:0] light,
  output logic [1:0]       state,
  output logic             step_pulse
`ifdef CHASER_LAP_CNT_EN
  ,
  output logic             lap_done,
  output logic [7:0]       lap_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } st_t;

  localparam logic [2:0] OP_START = 3'd1;
  localparam logic [2:0] OP_STOP  = 3'd2;
  localparam logic [2:0] OP_PAUSE = 3'd3;
  localparam logic [2:0] OP_MODE  = 3'd4;
  localparam logic [2:0] OP_DIV   = 3'd5;
  localparam logic [2:0] OP_STEP  = 3'd6;

  st_t              st_q, st_n;
  logic [WIDTH-1:0] light_q, light_n;
  logic [1:0]       mode_q, mode_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [DIV_W-1:0] presc_q, presc_n;
  logic             dir_q, dir_n;
  logic             pulse_q, pulse_n;
  logic [WIDTH-1:0] adv_light;
  logic             adv_dir;
  logic             accept;
  logic             do_adv;

  function automatic logic [WIDTH-1:0] seed(input logic [1:0] m);
    if (m == 2'd1)
      seed = {1'b1, {(WIDTH-1){1'b0}}};
    else
      seed = {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign cmd_ready  = enable;
  assign accept     = cmd_valid & enable;
  assign light      = light_q;
  assign state      = st_q;
  assign step_pulse = pulse_q & enable;

  // dir_q: 0 = moving toward MSB, 1 = moving toward LSB
  always_comb begin
    adv_light = light_q;
    adv_dir   = dir_q;
    unique case (mode_q)
      2'd0: adv_light = {light_q[WIDTH-2:0], light_q[WIDTH-1]};
      2'd1: adv_light = {light_q[0], light_q[WIDTH-1:1]};
      2'd2: begin
        if (!dir_q) begin
          adv_light = light_q << 1;
          if (adv_light[WIDTH-1]) adv_dir = 1'b1;
        end else begin
          adv_light = light_q >> 1;
          if (adv_light[0]) adv_dir = 1'b0;
        end
      end
      default: begin
        if (&light_q)
          adv_light = seed(2'd3);
        else
          adv_light = {light_q[WIDTH-2:0], 1'b1};
      end
    endcase
  end

  // An accepted command always pre-empts the prescaler in that cycle.
  always_comb begin
    st_n    = st_q;
    light_n = light_q;
    mode_n  = mode_q;
    div_n   = div_q;
    presc_n = presc_q;
    dir_n   = dir_q;
    pulse_n = 1'b0;
    do_adv  = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_START: begin
          st_n    = S_RUN;
          light_n = seed(mode_q);
          presc_n = '0;
          dir_n   = 1'b0;
        end
        OP_STOP: begin
          st_n    = S_IDLE;
          light_n = '0;
          presc_n = '0;
        end
        OP_PAUSE: begin
          if (st_q == S_RUN)
            st_n = S_PAUSE;
          else if (st_q == S_PAUSE)
            st_n = S_RUN;
        end
        OP_MODE: begin
          mode_n  = cmd_arg[1:0];
          presc_n = '0;
          dir_n   = 1'b0;
          if (st_q != S_IDLE) light_n = seed(cmd_arg[1:0]);
        end
        OP_DIV: begin
          div_n   = cmd_arg;
          presc_n = '0;
        end
        OP_STEP: do_adv = (st_q == S_PAUSE);
        default: ;
      endcase
    end else if (enable && st_q == S_RUN) begin
      if (presc_q == div_q) begin
        do_adv  = 1'b1;
        presc_n = '0;
      end else begin
        presc_n = presc_q + 1'b1;
      end
    end
    if (do_adv) begin
      light_n = adv_light;
      dir_n   = adv_dir;
      pulse_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      light_q <= '0;
      mode_q  <= 2'd0;
      div_q   <= DIV_W'(DEFAULT_DIV);
      presc_q <= '0;
      dir_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      st_q    <= st_n;
      light_q <= light_n;
      mode_q  <= mode_n;
      div_q   <= div_n;
      presc_q <= presc_n;
      dir_q   <= dir_n;
      pulse_q <= pulse_n;
    end
  end

`ifdef CHASER_LAP_CNT_EN
  logic       lap_q, lap_n;
  logic [7:0] lcnt_q, lcnt_n;
  logic       lap_clr;

  assign lap_clr = accept &&
    (cmd_op == OP_START || cmd_op == OP_STOP || cmd_op == OP_MODE);
  assign lap_done  = lap_q & enable;
  assign lap_count = lcnt_q;

  always_comb begin
    lap_n  = 1'b0;
    lcnt_n = lcnt_q;
    if (lap_clr) begin
      lcnt_n = 8'd0;
    end else if (do_adv && adv_light == seed(mode_q)) begin
      lap_n  = 1'b1;
      lcnt_n = lcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_q  <= 1'b0;
      lcnt_q <= 8'd0;
    end else begin
      lap_q  <= lap_n;
      lcnt_q <= lcnt_n;
    end
  end
`endif

endmodule
